dcache_sram_nway: RTL and testbench

//  Parametrised N-way set-associative L1 data-cache storage array with true-LRU replacement.
//  It holds per-way tag, valid, dirty and line data, does the hit lookup and picks the victim.
//  It sits between the dcache controller FSM and the tag/data datapath.
//  It generalises the 2-way array to WAYS ways and adds age-counter LRU, read-hit LRU update,

---
 rtl/dcache_sram_nway.sv | 123 ++++++++++++
 tb/tb_dcache_sram_nway.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway
//   N-way set-associative L1 data-cache storage array with true-LRU replacement.
//   Holds the tag, valid, dirty and line data of every way. Performs the hit lookup
//   and chooses the victim way.
//   Lookup is purely combinational on the current state of set addr_i. All updates
//   happen on the rising edge of clk_i.
// Ports
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   addr_i          set index
//   tag_i           lookup / allocate tag
//   data_i          write-hit data or refill line
//   enable_i        access strobe; state is untouched when low
//   write_i         1 = write (hit update or miss allocate), 0 = read
//   dirty_i         dirty value for the written way
//   hit_o           valid tag match in set addr_i
//   hit_way_o       matching way, or the victim way on a miss
//   tag_o           tag of the hit way, or the victim's tag
//   data_o          line of the hit way, or the victim's line
//   victim_dirty_o  miss, and the victim is valid and dirty
module dcache_sram_nway #(
  parameter  int SET_BITS = 4,
  parameter  int WAYS     = 4,
  parameter  int TAG_W    = 23,
  parameter  int LINE_W   = 256,
  localparam int SETS     = 2**SET_BITS,
  localparam int WB       = $clog2(WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SET_BITS-1:0] addr_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic [LINE_W-1:0]   data_i,
  input  logic                enable_i,
  input  logic                write_i,
  input  logic                dirty_i,
  output logic                hit_o,
  output logic [WB-1:0]       hit_way_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [LINE_W-1:0]   data_o,
  output logic                victim_dirty_o
);

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  // Per-set age counters: 0 = most recently used, WAYS-1 = least recently used.
  logic [WB-1:0]     age_q   [SETS][WAYS];

  logic          hit;
  logic [WB-1:0] hit_way;
  logic          found_inv;
  logic [WB-1:0] inv_way;
  logic [WB-1:0] lru_way;
  logic [WB-1:0] victim;
  logic [WB-1:0] sel;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      // Lowest matching way wins if several ways match.
      if (!hit && valid_q[addr_i][w] && tag_q[addr_i][w] == tag_i) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!found_inv && !valid_q[addr_i][w]) begin
        found_inv = 1'b1;
        inv_way   = WB'(w);
      end
      if (age_q[addr_i][w] == WB'(WAYS - 1)) begin
        lru_way = WB'(w);
      end
    end
    victim = found_inv ? inv_way : lru_way;
    sel    = hit ? hit_way : victim;
  end

  assign hit_o          = hit;
  assign hit_way_o      = sel;
  assign tag_o          = tag_q[addr_i][sel];
  assign data_o         = data_q[addr_i][sel];
  assign victim_dirty_o = !hit && valid_q[addr_i][sel] && dirty_q[addr_i][sel];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WB'(w);
        end
      end
    end else if (enable_i && (hit || write_i)) begin
      if (write_i) begin
        data_q[addr_i][sel] <= data_i;
        if (hit) begin
          dirty_q[addr_i][sel] <= dirty_q[addr_i][sel] | dirty_i;
        end else begin
          tag_q[addr_i][sel]   <= tag_i;
          valid_q[addr_i][sel] <= 1'b1;
          dirty_q[addr_i][sel] <= dirty_i;
        end
      end
      // Touch(sel): ways younger than sel age by one, sel becomes youngest.
      // All reads use pre-edge ages, so the set stays a permutation.
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WB'(w) == sel) begin
          age_q[addr_i][w] <= '0;
        end else if (age_q[addr_i][w] < age_q[addr_i][sel]) begin
          age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
module tb_dcache_sram_nway;
  localparam int SET_BITS = 4;
  localparam int WAYS     = 4;
  localparam int TAG_W    = 23;
  localparam int LINE_W   = 256;
  localparam int SETS     = 2**SET_BITS;
  localparam int WB       = $clog2(WAYS);

  logic                clk = 1'b0;
  logic                rst;
  logic [SET_BITS-1:0] addr;
  logic [TAG_W-1:0]    tag;
  logic [LINE_W-1:0]   data;
  logic                en, wr, dirty;
  logic                hit_o;
  logic [WB-1:0]       hit_way_o;
  logic [TAG_W-1:0]    tag_o;
  logic [LINE_W-1:0]   data_o;
  logic                victim_dirty_o;

  int checks = 0;
  int errors = 0;

  dcache_sram_nway #(.SET_BITS(SET_BITS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .tag_i(tag), .data_i(data),
    .enable_i(en), .write_i(wr), .dirty_i(dirty),
    .hit_o(hit_o), .hit_way_o(hit_way_o), .tag_o(tag_o), .data_o(data_o),
    .victim_dirty_o(victim_dirty_o)
  );

  always #5 clk = ~clk;

  // Reference model: per-set recency list, rank[s][0] = MRU way, rank[s][WAYS-1] = LRU way.
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int unsigned       rank    [SETS][WAYS];

  bit                exp_hit;
  int unsigned       exp_way;
  logic [TAG_W-1:0]  exp_tag;
  logic [LINE_W-1:0] exp_data;
  bit                exp_vd;

  localparam logic [TAG_W-1:0] TA = 23'hA, TB = 23'hB, TC = 23'hC, TD = 23'hD, TE = 23'hE;
  localparam logic [LINE_W-1:0] DEAD = {16{16'hDEAD}};

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_data[s][w] = '0;
        rank[s][w] = w;
      end
  endfunction

  function automatic void predict(int unsigned s, logic [TAG_W-1:0] t);
    int unsigned sel = 0;
    bit found = 0;
    exp_hit = 0;
    for (int w = 0; w < WAYS; w++)
      if (!exp_hit && m_valid[s][w] && m_tag[s][w] == t) begin exp_hit = 1; sel = w; end
    if (!exp_hit) begin
      sel = rank[s][WAYS-1];
      for (int w = 0; w < WAYS; w++)
        if (!found && !m_valid[s][w]) begin found = 1; sel = w; end
    end
    exp_way  = sel;
    exp_tag  = m_tag[s][sel];
    exp_data = m_data[s][sel];
    exp_vd   = !exp_hit && m_valid[s][sel] && m_dirty[s][sel];
  endfunction

  function automatic void touch(int unsigned s, int unsigned w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (rank[s][i] == w) p = i;
    for (int i = p; i > 0; i--) rank[s][i] = rank[s][i-1];
    rank[s][0] = w;
  endfunction

  function automatic int unsigned age_of(int unsigned s, int unsigned w);
    int unsigned a = 0;
    for (int i = 0; i < WAYS; i++) if (rank[s][i] == w) a = i;
    return a;
  endfunction

  task automatic set_in(input bit r, input bit e, input bit w, input int unsigned s,
                        input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d, input bit dt);
    rst = r; en = e; wr = w; addr = SET_BITS'(s); tag = t; data = d; dirty = dt;
  endtask

  // Update the model for the access currently on the inputs, then clock it into the DUT.
  task automatic step();
    if (rst) model_reset();
    else if (en) begin
      predict(addr, tag);
      if (exp_hit) begin
        if (wr) begin
          m_data[addr][exp_way] = data;
          m_dirty[addr][exp_way] = m_dirty[addr][exp_way] | dirty;
        end
        touch(addr, exp_way);
      end else if (wr) begin
        m_tag[addr][exp_way] = tag; m_valid[addr][exp_way] = 1;
        m_dirty[addr][exp_way] = dirty; m_data[addr][exp_way] = data;
        touch(addr, exp_way);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 3, 23'h5, rand_line(), 1);
    step();
    set_in(0, 1, 0, 3, 23'h1, '0, 0);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o, victim_dirty_o, tag_o} !== {1'b0, WB'(0), 1'b0, TAG_W'(0)}) begin
      errors++;
      $display("FAIL reset_outputs: got hit=%0b way=%0d vd=%0b tag=%0h want 0 0 0 0",
               hit_o, hit_way_o, victim_dirty_o, tag_o);
    end
    checks++;
    if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", data_o); end
    step();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        checks++;
        if (dut.age_q[s][w] !== WB'(w)) begin
          errors++;
          $display("FAIL reset_age[%0d][%0d]: got %0d want %0d", s, w, dut.age_q[s][w], w);
        end
      end
  endtask

  task automatic test_refill();
    logic [TAG_W-1:0] tags [4];
    tags[0] = TA; tags[1] = TB; tags[2] = TC; tags[3] = TD;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 1, 3, tags[i], rand_line(), 0);
      @(negedge clk);
      checks++;
      if ({hit_o, hit_way_o} !== {1'b0, WB'(i)}) begin
        errors++;
        $display("FAIL refill_way%0d: got hit=%0b way=%0d want hit=0 way=%0d", i, hit_o, hit_way_o, i);
      end
      step();
    end
    set_in(0, 1, 0, 3, TA, '0, 0);
    predict(3, TA);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o, data_o} !== {1'b1, WB'(0), exp_data}) begin
      errors++;
      $display("FAIL read_A: got hit=%0b way=%0d want hit=1 way=0", hit_o, hit_way_o);
    end
    step();
  endtask

  task automatic test_lru_evict();
    set_in(0, 1, 1, 3, TE, rand_line(), 0);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o, victim_dirty_o, tag_o} !== {1'b0, WB'(1), 1'b0, TB}) begin
      errors++;
      $display("FAIL evict_B: got hit=%0b way=%0d vd=%0b tag=%0h want 0 1 0 %0h",
               hit_o, hit_way_o, victim_dirty_o, tag_o, TB);
    end
    step();
    set_in(0, 1, 0, 3, TE, '0, 0);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o} !== {1'b1, WB'(1)}) begin
      errors++;
      $display("FAIL read_E: got hit=%0b way=%0d want 1 1", hit_o, hit_way_o);
    end
    step();
  endtask

  task automatic test_write_hit_dirty();
    bit evicted = 0;
    set_in(0, 1, 1, 3, TC, DEAD, 1);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o} !== {1'b1, WB'(2)}) begin
      errors++;
      $display("FAIL wrhit_C: got hit=%0b way=%0d want 1 2", hit_o, hit_way_o);
    end
    step();
    // Read-after-write in the very next cycle sees the new line.
    set_in(0, 1, 0, 3, TC, '0, 0);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o, data_o} !== {1'b1, WB'(2), DEAD}) begin
      errors++;
      $display("FAIL read_C: got hit=%0b way=%0d data=%0h want 1 2 %0h", hit_o, hit_way_o, data_o, DEAD);
    end
    step();
    for (int i = 0; i < 2 * WAYS && !evicted; i++) begin
      set_in(0, 1, 1, 3, TAG_W'(23'h100 + i), rand_line(), 0);
      predict(3, tag);
      @(negedge clk);
      checks++;
      if ({hit_o, hit_way_o, victim_dirty_o, tag_o, data_o} !==
          {exp_hit, WB'(exp_way), exp_vd, exp_tag, exp_data}) begin
        errors++;
        $display("FAIL evict_walk%0d: got way=%0d vd=%0b tag=%0h want way=%0d vd=%0b tag=%0h",
                 i, hit_way_o, victim_dirty_o, tag_o, exp_way, exp_vd, exp_tag);
      end
      if (exp_way == 2) begin
        evicted = 1;
        checks++;
        if ({victim_dirty_o, tag_o, data_o} !== {1'b1, TC, DEAD}) begin
          errors++;
          $display("FAIL evict_C: got vd=%0b tag=%0h data=%0h want 1 %0h %0h",
                   victim_dirty_o, tag_o, data_o, TC, DEAD);
        end
      end
      step();
    end
    checks++;
    if (!evicted) begin errors++; $display("FAIL evict_C_budget: got no eviction want way 2 evicted"); end
  endtask

  task automatic test_set_isolation();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1, $urandom_range(0, 1), 3, TAG_W'($urandom_range(0, 7)), rand_line(), $urandom_range(0, 1));
      step();
    end
    // Idle cycle with undefined payload must not disturb anything.
    set_in(0, 0, 1, 3, 'x, 'x, 1);
    step();
    set_in(0, 0, 0, 5, TA, '0, 0);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o, victim_dirty_o, tag_o, data_o} !== {1'b0, WB'(0), 1'b0, TAG_W'(0), LINE_W'(0)}) begin
      errors++;
      $display("FAIL set5_state: got hit=%0b way=%0d vd=%0b tag=%0h want 0 0 0 0",
               hit_o, hit_way_o, victim_dirty_o, tag_o);
    end
    for (int w = 0; w < WAYS; w++) begin
      checks++;
      if (dut.age_q[5][w] !== WB'(w)) begin
        errors++; $display("FAIL set5_age[%0d]: got %0d want %0d", w, dut.age_q[5][w], w);
      end
    end
    set_in(0, 1, 0, 3, TE, '0, 0);
    predict(3, TE);
    @(negedge clk);
    checks++;
    if ({hit_o, hit_way_o, victim_dirty_o, tag_o, data_o} !==
        {exp_hit, WB'(exp_way), exp_vd, exp_tag, exp_data}) begin
      errors++;
      $display("FAIL set3_after_idle: got hit=%0b way=%0d want hit=%0b way=%0d", hit_o, hit_way_o, exp_hit, exp_way);
    end
    step();
  endtask

  task automatic test_reset_collision();
    set_in(1, 1, 1, 3, 23'h77, rand_line(), 1);
    step();
    for (int s = 0; s < SETS; s++) begin
      set_in(0, 0, 0, s, 23'h77, '0, 0);
      @(negedge clk);
      checks++;
      if ({hit_o, hit_way_o, victim_dirty_o, tag_o} !== {1'b0, WB'(0), 1'b0, TAG_W'(0)}) begin
        errors++;
        $display("FAIL rst_collide_set%0d: got hit=%0b way=%0d vd=%0b tag=%0h want 0 0 0 0",
                 s, hit_o, hit_way_o, victim_dirty_o, tag_o);
      end
      for (int w = 0; w < WAYS; w++) begin
        checks++;
        if (dut.age_q[s][w] !== WB'(w)) begin
          errors++; $display("FAIL rst_collide_age[%0d][%0d]: got %0d want %0d", s, w, dut.age_q[s][w], w);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int unsigned s;
      bit [WAYS-1:0] seen;
      s = $urandom_range(0, 3) * 5;
      set_in(0, $urandom_range(0, 7) != 0, $urandom_range(0, 1), s,
             TAG_W'($urandom_range(0, 6)), rand_line(), $urandom_range(0, 1));
      predict(s, tag);
      @(negedge clk);
      checks++;
      if ({hit_o, hit_way_o, victim_dirty_o, tag_o, data_o} !==
          {exp_hit, WB'(exp_way), exp_vd, exp_tag, exp_data}) begin
        errors++;
        $display("FAIL rand%0d: got hit=%0b way=%0d vd=%0b tag=%0h want hit=%0b way=%0d vd=%0b tag=%0h",
                 i, hit_o, hit_way_o, victim_dirty_o, tag_o, exp_hit, exp_way, exp_vd, exp_tag);
      end
      seen = '0;
      for (int w = 0; w < WAYS; w++) begin
        seen[dut.age_q[s][w]] = 1'b1;
        checks++;
        if (dut.age_q[s][w] !== WB'(age_of(s, w))) begin
          errors++;
          $display("FAIL rand_age%0d[%0d][%0d]: got %0d want %0d", i, s, w, dut.age_q[s][w], age_of(s, w));
        end
      end
      checks++;
      if (seen !== '1) begin errors++; $display("FAIL rand_perm%0d: got coverage %0b want all ones", i, seen); end
      step();
    end
  endtask

  initial begin
    set_in(1, 0, 0, 0, '0, '0, 0);
    test_reset();
    test_refill();
    test_lru_evict();
    test_write_hit_dirty();
    test_set_isolation();
    test_reset_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
